// File: rtl/kronos_fetch_queue.sv
// -----------------------------------------------------------------------------
// kronos_fetch_queue
//   Decoupling instruction queue between the fetch stage (kronos_IF) and the
//   decode stage. Fetched (pc, ir) pairs are buffered in a DEPTH-entry circular
//   store and handed to decode in order. A branch flush discards everything.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rstz       : asynchronous active-low reset
//   fetch_pc   : PC of the instruction offered by IF
//   fetch_ir   : instruction word offered by IF
//   fetch_vld  : IF offers fetch_pc/fetch_ir
//   fetch_rdy  : queue accepts the offered entry this cycle
//   decode_pc  : PC at the queue head
//   decode_ir  : instruction word at the queue head
//   decode_vld : head entry is valid
//   decode_rdy : decode consumes the head entry this cycle
//   flush      : branch/redirect, discard all buffered entries
//   count      : current occupancy (0..DEPTH)
//
// Also contains kronos_fetch_queue_chk, a simulation-only checker holding the
// occupancy assertions; the top instantiates it.
// -----------------------------------------------------------------------------

module kronos_fetch_queue_chk #(
    parameter int DEPTH = 4
) (
    input logic                         clk,
    input logic                         rstz,
    input logic                         push,
    input logic                         pop,
    input logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    a_no_push_when_full : assert property (
        @(posedge clk) disable iff (!rstz) push |-> (count != FULL_CNT)
    ) else $error("kronos_fetch_queue: push while full");

    a_no_pop_when_empty : assert property (
        @(posedge clk) disable iff (!rstz) pop |-> (count != {CW{1'b0}})
    ) else $error("kronos_fetch_queue: pop while empty");

    a_count_in_range : assert property (
        @(posedge clk) disable iff (!rstz) count <= FULL_CNT
    ) else $error("kronos_fetch_queue: occupancy above DEPTH");

endmodule

module kronos_fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rstz,
    input  logic [31:0]                  fetch_pc,
    input  logic [31:0]                  fetch_ir,
    input  logic                         fetch_vld,
    output logic                         fetch_rdy,
    output logic [31:0]                  decode_pc,
    output logic [31:0]                  decode_ir,
    output logic                         decode_vld,
    input  logic                         decode_rdy,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [31:0]   pc_mem_r [DEPTH];
    logic [31:0]   ir_mem_r [DEPTH];
    logic [PW-1:0] rptr_r;
    logic [PW-1:0] wptr_r;
    logic [CW-1:0] count_r;

    logic          fetch_rdy_s;
    logic          decode_vld_s;
    logic          push_s;
    logic          pop_s;

    // Handshake qualifiers. Both depend only on the registered occupancy and
    // flush, so fetch_rdy never sees decode_rdy: a full queue refuses a push
    // even when a pop happens in the same cycle.
    always_comb begin
        fetch_rdy_s  = 1'b0;
        decode_vld_s = 1'b0;
        if (flush) begin
            fetch_rdy_s  = 1'b0;
            decode_vld_s = 1'b0;
        end else begin
            fetch_rdy_s  = (count_r != FULL_CNT);
            decode_vld_s = (count_r != {CW{1'b0}});
        end
        push_s = fetch_vld && fetch_rdy_s;
        pop_s  = decode_vld_s && decode_rdy;
    end

    // Entry storage: written at wptr on an accepted push, cleared by reset.
    // Flush leaves the data in place; it is unreachable once count is zero.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i] <= 32'h0000_0000;
                ir_mem_r[i] <= 32'h0000_0000;
            end
        end else if (push_s) begin
            pc_mem_r[wptr_r] <= fetch_pc;
            ir_mem_r[wptr_r] <= fetch_ir;
        end
    end

    // Pointers and occupancy. Pointers are log2(DEPTH) wide and wrap on
    // their own; flush wins over any handshake in the same cycle.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            rptr_r  <= {PW{1'b0}};
            wptr_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (flush) begin
            rptr_r  <= {PW{1'b0}};
            wptr_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + PW'(1'b1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PW'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign fetch_rdy  = fetch_rdy_s;
    assign decode_vld = decode_vld_s;
    assign decode_pc  = pc_mem_r[rptr_r];
    assign decode_ir  = ir_mem_r[rptr_r];
    assign count      = count_r;

    kronos_fetch_queue_chk #(
        .DEPTH (DEPTH)
    ) u_chk (
        .clk   (clk),
        .rstz  (rstz),
        .push  (push_s),
        .pop   (pop_s),
        .count (count_r)
    );

endmodule

// File: tb/tb_kronos_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_kronos_fetch_queue
//   Randomized, scoreboard-checked bench for kronos_fetch_queue (DEPTH=4).
//   The reference model is a plain SystemVerilog queue of (pc, ir) pairs with
//   a DEPTH capacity. A driver process issues stimulus just after each rising
//   edge; a monitor on the falling edge compares DUT outputs with the model,
//   then applies the coming edge's push/pop/flush to the model.
// -----------------------------------------------------------------------------

module tb_kronos_fetch_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rstz;
    logic [31:0]   fetch_pc;
    logic [31:0]   fetch_ir;
    logic          fetch_vld;
    logic          fetch_rdy;
    logic [31:0]   decode_pc;
    logic [31:0]   decode_ir;
    logic          decode_vld;
    logic          decode_rdy;
    logic          flush;
    logic [CW-1:0] count;

    int compared   = 0;
    int mismatched = 0;

    logic [63:0] sb[$];      // expected queue contents {pc, ir}, head at [0]
    bit          acc;        // model: offer is accepted at the coming edge
    int          delivered;  // entries popped by the model

    kronos_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rstz       (rstz),
        .fetch_pc   (fetch_pc),
        .fetch_ir   (fetch_ir),
        .fetch_vld  (fetch_vld),
        .fetch_rdy  (fetch_rdy),
        .decode_pc  (decode_pc),
        .decode_ir  (decode_ir),
        .decode_vld (decode_vld),
        .decode_rdy (decode_rdy),
        .flush      (flush),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare against the model, then advance the model.
    always @(negedge clk) begin
        bit          exp_rdy;
        bit          exp_vld;
        logic [63:0] head;
        if (!rstz) begin
            chk("rst_count", 64'(count), 64'd0);
            chk("rst_vld",   64'(decode_vld), 64'd0);
            chk("rst_rdy",   64'(fetch_rdy), 64'd1);
            chk("rst_pc",    64'(decode_pc), 64'd0);
            chk("rst_ir",    64'(decode_ir), 64'd0);
            sb.delete();
            acc = 1'b0;
        end else begin
            exp_rdy = (sb.size() != DEPTH) && !flush;
            exp_vld = (sb.size() != 0) && !flush;
            chk("count",      64'(count), 64'(sb.size()));
            chk("fetch_rdy",  64'(fetch_rdy), 64'(exp_rdy));
            chk("decode_vld", 64'(decode_vld), 64'(exp_vld));
            if (exp_vld) begin
                head = sb[0];
                chk("decode_pc", 64'(decode_pc), 64'(head[63:32]));
                chk("decode_ir", 64'(decode_ir), 64'(head[31:0]));
            end
            if (flush) begin
                sb.delete();
                acc = 1'b0;
            end else begin
                if (exp_vld && decode_rdy) begin
                    void'(sb.pop_front());
                    delivered++;
                end
                acc = fetch_vld && exp_rdy;
                if (acc) sb.push_back({fetch_pc, fetch_ir});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One cycle of directed stimulus; ir is derived from pc.
    task automatic cyc(input bit v, input logic [31:0] pc, input bit rdy, input bit fl);
        fetch_vld  = v;
        fetch_pc   = pc;
        fetch_ir   = ~pc;
        decode_rdy = rdy;
        flush      = fl;
        step();
    endtask

    // Sequential pcs from base, IF holds each offer until the model accepts it.
    task automatic run_stream(input int n, input logic [31:0] base, input bit gaps, input bit stalls);
        int          idx = 0;
        int          stall = 0;
        int          ncyc = 0;
        int          start_del = delivered;
        logic [31:0] cur_ir = $urandom;
        flush = 1'b0;
        while (idx < n && ncyc < n * 20 + 200) begin
            fetch_vld = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            fetch_pc  = base + 32'(idx) * 32'd4;
            fetch_ir  = cur_ir;
            if (!stalls) begin
                decode_rdy = 1'b1;
            end else if (stall > 0) begin
                decode_rdy = 1'b0;
                stall--;
            end else begin
                decode_rdy = 1'b1;
                if ($urandom_range(0, 3) == 0) stall = $urandom_range(1, 4);
            end
            step();
            ncyc++;
            if (acc) begin
                idx++;
                cur_ir = $urandom;
            end
        end
        chk("stream_sent", 64'(idx), 64'(n));
        fetch_vld  = 1'b0;
        decode_rdy = 1'b1;
        for (int k = 0; k < 40 && sb.size() != 0; k++) step();
        chk("stream_drained", 64'(sb.size()), 64'd0);
        chk("stream_delivered", 64'(delivered - start_del), 64'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        delivered  = 0;
        acc        = 1'b0;
        // 1. Reset with IF offering.
        rstz       = 1'b0;
        fetch_vld  = 1'b1;
        fetch_pc   = 32'h0;
        fetch_ir   = 32'h1234_5678;
        decode_rdy = 1'b0;
        flush      = 1'b0;
        repeat (3) step();
        rstz = 1'b1;
        step();                       // pc=0 accepted on this edge
        chk("first_push_vld", 64'(decode_vld), 64'd1);
        chk("first_push_pc",  64'(decode_pc), 64'd0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // 2. Streaming with decode always ready.
        run_stream(16, 32'h0, 1'b0, 1'b0);

        // 3. Fill and drain.
        cyc(1'b1, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 32'h4, 1'b0, 1'b0);
        cyc(1'b1, 32'h8, 1'b0, 1'b0);
        cyc(1'b1, 32'hC, 1'b0, 1'b0);
        chk("full_count", 64'(count), 64'(DEPTH));
        chk("full_rdy",   64'(fetch_rdy), 64'd0);
        cyc(1'b1, 32'h10, 1'b0, 1'b0);  // held by IF
        cyc(1'b1, 32'h10, 1'b1, 1'b0);  // pop only, push refused while full
        chk("rdy_after_pop", 64'(fetch_rdy), 64'd1);
        cyc(1'b1, 32'h10, 1'b1, 1'b0);
        repeat (6) cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // 4. Long randomized run with wrap-around, gaps and stalls.
        run_stream(1024, 32'h1000, 1'b1, 1'b1);

        // 5. Flush while full with an offer pending.
        cyc(1'b1, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 32'h4, 1'b0, 1'b0);
        cyc(1'b1, 32'h8, 1'b0, 1'b0);
        cyc(1'b1, 32'hC, 1'b0, 1'b0);
        cyc(1'b1, 32'h20, 1'b0, 1'b1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_vld",   64'(decode_vld), 64'd0);
        cyc(1'b1, 32'h100, 1'b0, 1'b0);
        chk("post_flush_pc", 64'(decode_pc), 64'h100);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        repeat (2) cyc(1'b0, 32'h0, 1'b1, 1'b0);

        // 6. Asynchronous reset mid-operation.
        cyc(1'b1, 32'h200, 1'b0, 1'b0);
        cyc(1'b1, 32'h204, 1'b0, 1'b0);
        cyc(1'b1, 32'h208, 1'b0, 1'b0);
        fetch_vld = 1'b0;
        chk("pre_rst_count", 64'(count), 64'd3);
        #2;
        rstz = 1'b0;
        #1;
        chk("async_rst_count", 64'(count), 64'd0);
        chk("async_rst_vld",   64'(decode_vld), 64'd0);
        step();
        rstz = 1'b1;
        repeat (4) cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("no_stale_vld", 64'(decode_vld), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/kronos_fetch_queue.md
Name: kronos_fetch_queue

Overview:
- Decoupling instruction queue between the fetch stage (kronos_IF) and the decode stage.
- Accepts fetched (pc, ir) pairs over a valid/ready handshake and buffers up to DEPTH entries.
- Presents entries in order to decode over a second valid/ready handshake.
- Absorbs decode backpressure and discards all buffered instructions on a branch flush.

Parameters:
- DEPTH, 4: number of queue entries; must be a power of 2 and at least 2.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rstz  input  1  asynchronous active-low reset.
- fetch_pc  input  32  PC of the incoming instruction from IF.
- fetch_ir  input  32  instruction word from IF.
- fetch_vld  input  1  IF offers fetch_pc/fetch_ir.
- fetch_rdy  output  1  queue accepts the offered entry this cycle.
- decode_pc  output  32  PC at queue head.
- decode_ir  output  32  instruction word at queue head.
- decode_vld  output  1  head entry valid.
- decode_rdy  input  1  decode consumes the head entry this cycle.
- flush  input  1  branch or redirect; discard all entries.
- count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (rstz low, asynchronous):
  - read pointer, write pointer and count go to 0; all storage entries go to 0.
  - decode_vld=0, decode_pc=0, decode_ir=0, fetch_rdy=1.
  - Takes effect immediately, including mid-operation. All in-flight entries are lost.
- Push: occurs when fetch_vld && fetch_rdy. The entry is written at wptr on the rising edge and wptr increments modulo DEPTH.
- Pop: occurs when decode_vld && decode_rdy. rptr increments modulo DEPTH.
- Pointers are log2(DEPTH) bits and wrap naturally; full and empty are derived from count.
- fetch_rdy = (count != DEPTH) && !flush. It must not depend combinationally on decode_rdy. When full, a push is refused even if a pop happens in the same cycle.
- decode_vld = (count != 0) && !flush.
- decode_pc and decode_ir always reflect storage[rptr].
- Latency: an entry pushed on edge N is visible at decode on cycle N+1 (one cycle of fill-through). There is no combinational path from fetch inputs to decode outputs.
- Count update per edge:
  - +1 on push only;
  - -1 on pop only;
  - unchanged on simultaneous push and pop (allowed when count is between 1 and DEPTH-1).
- Throughput: one entry per cycle sustained when decode_rdy=1, with count holding at 1.
- Hold rule: while decode_vld=1 and decode_rdy=0, decode_pc and decode_ir are stable.
- Flush (synchronous, one cycle):
  - No push or pop is performed in the flush cycle.
  - On the edge, rptr, wptr and count go to 0.
  - A fetch entry offered during the flush cycle is dropped. IF is redirected by the same branch, so this is safe.
  - Flush has priority over push and pop.
  - Flush while empty is a no-op apart from resetting the pointers.
- count is never allowed to exceed DEPTH or underflow. Simulation assertions flag a push when full or a pop when empty.

Test Plan:
1. Reset: hold rstz=0 with fetch_vld=1 -> count=0, decode_vld=0, fetch_rdy=1, decode_pc=0, decode_ir=0. After release, the first push at pc=0 appears one cycle later.
2. Streaming (DEPTH=4), decode_rdy=1, pc=0,4,8,... every cycle -> decode_vld rises one cycle after the first accept. Then one entry per cycle, pcs in order, count stays 1, fetch_rdy stays 1.
3. Fill and drain, decode_rdy=0, push pc=0x0,0x4,0x8,0xC -> count=4, fetch_rdy=0, and pc=0x10 is held by IF. Then decode_rdy=1 -> decode sees 0x0, 0x4, 0x8, 0xC, 0x10 in order, with fetch_rdy=1 the cycle after the first pop.
4. Wrap-around: 1024 sequential pcs with ir=random, random decode_rdy stalls of 1-4 cycles and random fetch_vld gaps -> every (pc, ir) pair is delivered exactly once, in order, pc incrementing by 4.
5. Flush while full with fetch_vld=1 (pc=0x20) -> next cycle count=0, decode_vld=0, and 0x20 is not stored. A new push at pc=0x100 reaches decode one cycle later.
6. Reset mid-operation: drop rstz asynchronously (off-edge) when count=3 -> count=0 and decode_vld=0 without waiting for a clock edge. After release, no stale entry appears at decode.
